// File: rtl/cmp_hysteresis_monitor_if.sv
// Comparator result bus: one sample of greater/lesser/equal flags qualified by in_valid.
// Latency: none, wires only.
// Backpressure: none; the consumer takes every valid sample.
interface cmp_hysteresis_monitor_if;
    logic in_valid;
    logic greater;
    logic lesser;
    logic equal;

    modport master (output in_valid, output greater, output lesser, output equal);
    modport slave  (input  in_valid, input  greater, input  lesser, input  equal);
endinterface

// File: rtl/cmp_hysteresis_monitor.sv
// Debounced hysteresis alarm, saturating per-result counters and one-hot check on comparator flags.
// Latency: 1 cycle from a sample to every registered output.
// Backpressure: none; one sample is consumed per in_valid cycle, gaps hold all state.
module cmp_hysteresis_monitor #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cmp_hysteresis_monitor_if.slave smp,
    input  logic                   clear_counts,
    output logic                   alarm,
    output logic                   alarm_rise,
    output logic                   alarm_fall,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       gt_count,
    output logic [CNT_W-1:0]       lt_count,
    output logic [CNT_W-1:0]       eq_count,
    output logic                   flag_error
);

    localparam int                 RUN_W    = $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ALARM     = 2'd2,
        ST_DISARMING = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             one_hot;
    logic             legal;

    assign one_hot = (smp.greater & ~smp.lesser & ~smp.equal) |
                     (~smp.greater & smp.lesser & ~smp.equal) |
                     (~smp.greater & ~smp.lesser & smp.equal);
    assign legal   = smp.in_valid & one_hot;

    // Any non-qualifying legal sample breaks a streak; illegal or invalid samples are invisible here.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        run_inc = run_q + RUN_W'(1);
        if (legal) begin
            case (state_q)
                ST_LOW: begin
                    if (smp.greater) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_ALARM;
                        end else begin
                            state_d = ST_ARMING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (smp.greater) begin
                        if (run_inc == RUN_LAST) begin
                            state_d = ST_ALARM;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = ST_LOW;
                        run_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (smp.lesser) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_LOW;
                        end else begin
                            state_d = ST_DISARMING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_DISARMING: begin
                    if (smp.lesser) begin
                        if (run_inc == RUN_LAST) begin
                            state_d = ST_LOW;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = ST_ALARM;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOW;
            run_q      <= '0;
            alarm_rise <= 1'b0;
            alarm_fall <= 1'b0;
            flag_error <= 1'b0;
            gt_count   <= '0;
            lt_count   <= '0;
            eq_count   <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            // Bit 1 of the state encoding is the alarm level.
            alarm_rise <= ~state_q[1] & state_d[1];
            alarm_fall <= state_q[1] & ~state_d[1];
            flag_error <= smp.in_valid & ~one_hot;
            if (clear_counts) begin
                gt_count <= '0;
                lt_count <= '0;
                eq_count <= '0;
            end else if (legal) begin
                if (smp.greater && gt_count != CNT_MAX) gt_count <= gt_count + CNT_W'(1);
                if (smp.lesser  && lt_count != CNT_MAX) lt_count <= lt_count + CNT_W'(1);
                if (smp.equal   && eq_count != CNT_MAX) eq_count <= eq_count + CNT_W'(1);
            end
        end
    end

    assign state = state_q;
    assign alarm = state_q[1];

endmodule

// File: tb/tb_cmp_hysteresis_monitor.sv
// Bench for cmp_hysteresis_monitor at DEBOUNCE=3, CNT_W=4: reference model feeds a scoreboard queue,
// plus fixed expectations for each directed scenario.
module tb_cmp_hysteresis_monitor;

    localparam int DEB = 3;
    localparam int CW  = 4;

    typedef struct packed {
        logic [1:0]    state;
        logic          alarm;
        logic          rise;
        logic          fall;
        logic          ferr;
        logic [CW-1:0] gt;
        logic [CW-1:0] lt;
        logic [CW-1:0] eq;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_counts = 1'b0;
    logic          alarm, alarm_rise, alarm_fall, flag_error;
    logic [1:0]    state;
    logic [CW-1:0] gt_count, lt_count, eq_count;

    cmp_hysteresis_monitor_if smp_if ();

    cmp_hysteresis_monitor #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .smp          (smp_if.slave),
        .clear_counts (clear_counts),
        .alarm        (alarm),
        .alarm_rise   (alarm_rise),
        .alarm_fall   (alarm_fall),
        .state        (state),
        .gt_count     (gt_count),
        .lt_count     (lt_count),
        .eq_count     (eq_count),
        .flag_error   (flag_error)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    int m_state = 0, m_run = 0, m_gt = 0, m_lt = 0, m_eq = 0;
    bit m_rise = 0, m_fall = 0, m_ferr = 0;

    // Drive one cycle of stimulus, advance the model, queue the expectation, then capture the DUT.
    task automatic step(input logic r, input logic v, input logic g, input logic l,
                        input logic e, input logic c);
        obs_t ex, ob;
        bit   legal, a_old;
        rst = r; smp_if.in_valid = v; smp_if.greater = g; smp_if.lesser = l;
        smp_if.equal = e; clear_counts = c;
        a_old = (m_state >= 2);
        if (r) begin
            m_state = 0; m_run = 0; m_gt = 0; m_lt = 0; m_eq = 0;
            m_rise = 0; m_fall = 0; m_ferr = 0;
        end else begin
            legal  = v && (int'(g) + int'(l) + int'(e) == 1);
            m_ferr = v && !legal;
            if (legal) begin
                if (m_state == 0) begin
                    if (g) begin m_state = 1; m_run = 1; end
                end else if (m_state == 1) begin
                    if (g) begin
                        m_run++;
                        if (m_run == DEB) begin m_state = 2; m_run = 0; end
                    end else begin m_state = 0; m_run = 0; end
                end else if (m_state == 2) begin
                    if (l) begin m_state = 3; m_run = 1; end
                end else begin
                    if (l) begin
                        m_run++;
                        if (m_run == DEB) begin m_state = 0; m_run = 0; end
                    end else begin m_state = 2; m_run = 0; end
                end
            end
            if (c) begin
                m_gt = 0; m_lt = 0; m_eq = 0;
            end else if (legal) begin
                if (g && m_gt < 15) m_gt++;
                if (l && m_lt < 15) m_lt++;
                if (e && m_eq < 15) m_eq++;
            end
            m_rise = !a_old && (m_state >= 2);
            m_fall = a_old && (m_state < 2);
        end
        ex.state = 2'(m_state); ex.alarm = (m_state >= 2); ex.rise = m_rise; ex.fall = m_fall;
        ex.ferr = m_ferr; ex.gt = CW'(m_gt); ex.lt = CW'(m_lt); ex.eq = CW'(m_eq);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ob.state = state; ob.alarm = alarm; ob.rise = alarm_rise; ob.fall = alarm_fall;
        ob.ferr = flag_error; ob.gt = gt_count; ob.lt = lt_count; ob.eq = eq_count;
        obs_q.push_back(ob);
    endtask

    task automatic sample(input logic g, input logic l, input logic e);
        step(1'b0, 1'b1, g, l, e, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t e, o;
        do_reset();
        checks++;
        if ({state, alarm, alarm_rise, alarm_fall, flag_error, gt_count, lt_count, eq_count} !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h required=0", {state, alarm, gt_count, lt_count, eq_count});
        end
        sample(1, 0, 0);
        sample(1, 0, 0);
        do_reset();
        checks++;
        if ({state, alarm, alarm_rise, alarm_fall, flag_error, gt_count, lt_count, eq_count} !== '0) begin
            errors++;
            $display("FAIL reset_midstream: outputs=%h required=0", {state, alarm, gt_count, lt_count, eq_count});
        end
        sample(1, 0, 0);
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL reset_first_g: state=%0d required=1", state); end
        sample(1, 0, 0);
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL reset_streak_lost: state=%0d required=1", state); end
        sample(1, 0, 0);
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL reset_rearm: state=%0d required=2", state); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_reset: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_gaps();
        obs_t e, o;
        do_reset();
        sample(1, 0, 0);
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL gaps_s1: state=%0d required=1", state); end
        gap(); gap();
        sample(1, 0, 0);
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL gaps_s2: state=%0d required=1", state); end
        gap();
        sample(1, 0, 0);
        checks++;
        if ({state, alarm, alarm_rise, gt_count} !== {2'd2, 1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL gaps_alarm: state=%0d alarm=%b rise=%b gt=%0d required 2 1 1 3",
                     state, alarm, alarm_rise, gt_count);
        end
        gap();
        checks++;
        if ({alarm, alarm_rise} !== 2'b10) begin
            errors++; $display("FAIL gaps_rise_width: alarm=%b rise=%b required 1 0", alarm, alarm_rise);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_gaps: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_equal_breaks();
        obs_t e, o;
        do_reset();
        sample(1, 0, 0); sample(1, 0, 0); sample(0, 0, 1); sample(1, 0, 0);
        checks++;
        if ({state, alarm, eq_count, gt_count} !== {2'd1, 1'b0, 4'd1, 4'd3}) begin
            errors++;
            $display("FAIL equal_breaks: state=%0d alarm=%b eq=%0d gt=%0d required 1 0 1 3",
                     state, alarm, eq_count, gt_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_equal: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_disarm();
        obs_t e, o;
        logic [1:0] seq_exp [5] = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [2:0] lpat    [5] = '{3'b010, 3'b100, 3'b010, 3'b010, 3'b010};
        int falls = 0;
        do_reset();
        sample(1, 0, 0); sample(1, 0, 0); sample(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            sample(lpat[i][2], lpat[i][1], lpat[i][0]);
            if (alarm_fall) falls++;
            checks++;
            if (state !== seq_exp[i]) begin
                errors++; $display("FAIL disarm_seq%0d: state=%0d required=%0d", i, state, seq_exp[i]);
            end
        end
        checks++;
        if ({alarm, alarm_fall, lt_count} !== {1'b0, 1'b1, 4'd4} || falls != 1) begin
            errors++;
            $display("FAIL disarm_fall: alarm=%b fall=%b lt=%0d falls=%0d required 0 1 4 1",
                     alarm, alarm_fall, lt_count, falls);
        end
        gap();
        checks++;
        if (alarm_fall !== 1'b0) begin errors++; $display("FAIL disarm_fall_width: fall=%b required 0", alarm_fall); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_disarm: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_saturate_clear();
        obs_t e, o;
        do_reset();
        for (int i = 0; i < 20; i++) sample(1, 0, 0);
        checks++;
        if ({gt_count, state} !== {4'd15, 2'd2}) begin
            errors++; $display("FAIL sat_gt: gt=%0d state=%0d required 15 2", gt_count, state);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({gt_count, lt_count, eq_count, state} !== {12'd0, 2'd3}) begin
            errors++;
            $display("FAIL clear_with_lesser: gt=%0d lt=%0d eq=%0d state=%0d required 0 0 0 3",
                     gt_count, lt_count, eq_count, state);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_saturate: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_flag_error();
        obs_t e, o;
        do_reset();
        sample(1, 0, 0); sample(1, 0, 0); sample(1, 0, 0);
        sample(1, 1, 0);
        checks++;
        if ({flag_error, state, gt_count, lt_count} !== {1'b1, 2'd2, 4'd3, 4'd0}) begin
            errors++;
            $display("FAIL ferr_110: ferr=%b state=%0d gt=%0d lt=%0d required 1 2 3 0",
                     flag_error, state, gt_count, lt_count);
        end
        sample(0, 0, 0);
        checks++;
        if ({flag_error, state, gt_count} !== {1'b1, 2'd2, 4'd3}) begin
            errors++;
            $display("FAIL ferr_000: ferr=%b state=%0d gt=%0d required 1 2 3", flag_error, state, gt_count);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flag_error !== 1'b0) begin errors++; $display("FAIL ferr_invalid: ferr=%b required 0", flag_error); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_flag_error: got=%h required=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        logic [2:0] f;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
            else f = 3'b001 << $urandom_range(0, 2);
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                 f[2], f[1], f[0], 1'($urandom_range(0, 31) == 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_random: got=%h required=%h", o, e); end
        end
    endtask

    initial begin
        smp_if.in_valid = 1'b0;
        smp_if.greater  = 1'b0;
        smp_if.lesser   = 1'b0;
        smp_if.equal    = 1'b0;
        test_reset();
        test_gaps();
        test_equal_breaks();
        test_disarm();
        test_saturate_clear();
        test_flag_error();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
